// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode enum and load-width helper.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_t;

    // The load counter must be able to hold every value from 0 up to 2**addrW.
    function automatic int fifoLoadWidth(input int addrW);
        return addrW + 1;
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: one write port and one read port with a registered, enable-held output.
module dpram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_wClk,
    input  logic              i_wEn,
    input  logic [ADDR_W-1:0] i_wAddr,
    input  logic [DATA_W-1:0] i_wData,
    input  logic              i_rClk,
    input  logic              i_rRst,
    input  logic              i_rEn,
    input  logic [ADDR_W-1:0] i_rAddr,
    output logic [DATA_W-1:0] o_rData
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rData;

    // Store the incoming word; the array itself is never cleared.
    always_ff @(posedge i_wClk) begin
        if (i_wEn) begin
            r_mem[i_wAddr] <= i_wData;
        end
    end

    // Output register only updates on an enabled read, so data holds between reads.
    always_ff @(posedge i_rClk) begin
        if (i_rRst) begin
            r_rData <= '0;
        end else if (i_rEn) begin
            r_rData <= r_mem[i_rAddr];
        end
    end

    assign o_rData = r_rData;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, level flags and sticky errors.
module fifo_sync #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int WORDS_TOTAL = 2**ADDR_W,
    parameter int FWFT        = 0,
    parameter int AFULL_THR   = WORDS_TOTAL - 1,
    parameter int AEMPTY_THR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    output logic              wfull,
    output logic              wafull,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rempty,
    output logic              raempty,
    output logic [ADDR_W:0]   load,
    output logic              ovf,
    output logic              udf,
    input  logic              err_clr
);
    import fifo_pkg::*;

    localparam int                LOAD_W   = fifoLoadWidth(ADDR_W);
    localparam fifo_mode_t        MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [LOAD_W-1:0] C_FULL   = LOAD_W'(WORDS_TOTAL);
    localparam logic [LOAD_W-1:0] C_AFULL  = LOAD_W'(AFULL_THR);
    localparam logic [LOAD_W-1:0] C_AEMPTY = LOAD_W'(AEMPTY_THR);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(WORDS_TOTAL - 1);

    logic [ADDR_W-1:0] r_wPtr;
    logic [ADDR_W-1:0] r_rPtr;
    logic [LOAD_W-1:0] r_load;
    logic              r_rvalid;
    logic              r_ovf;
    logic              r_udf;

    logic              w_full;
    logic              w_rempty;
    logic              w_wrAccept;
    logic              w_pop;
    logic              w_memHas;
    logic              w_fetch;

    // Flags are decoded from the registered load, so they trail the causing event by a cycle.
    assign w_full   = (r_load == C_FULL);
    assign w_rempty = (MODE == FIFO_FWFT) ? ~r_rvalid : (r_load == '0);

    assign w_wrAccept = wen & ~w_full;
    assign w_pop      = ren & ~w_rempty;

    // In FWFT the output register holds one counted word; anything beyond it is still in the RAM.
    assign w_memHas = (r_load > {{(LOAD_W-1){1'b0}}, r_rvalid});
    assign w_fetch  = (MODE == FIFO_FWFT) ? (w_memHas & (~r_rvalid | w_pop)) : w_pop;

    dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_wClk  (clk),
        .i_wEn   (w_wrAccept & ~rst),
        .i_wAddr (r_wPtr),
        .i_wData (wdata),
        .i_rClk  (clk),
        .i_rRst  (rst),
        .i_rEn   (w_fetch & ~rst),
        .i_rAddr (r_rPtr),
        .o_rData (rdata)
    );

    // Pointers wrap at the usable capacity; load tracks accepted writes minus accepted pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wPtr <= '0;
            r_rPtr <= '0;
            r_load <= '0;
        end else begin
            if (w_wrAccept) begin
                r_wPtr <= (r_wPtr == PTR_LAST) ? '0 : r_wPtr + 1'b1;
            end
            if (w_fetch) begin
                r_rPtr <= (r_rPtr == PTR_LAST) ? '0 : r_rPtr + 1'b1;
            end
            case ({w_wrAccept, w_pop})
                2'b10:   r_load <= r_load + 1'b1;
                2'b01:   r_load <= r_load - 1'b1;
                default: r_load <= r_load;
            endcase
        end
    end

    // Standard mode flags one cycle after a read; FWFT holds valid until the head is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
        end else if (MODE == FIFO_FWFT) begin
            r_rvalid <= w_fetch | (r_rvalid & ~w_pop);
        end else begin
            r_rvalid <= w_fetch;
        end
    end

    // Sticky error bits; a new error in the same cycle wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wen & w_full) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (ren & w_rempty) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign wfull   = w_full;
    assign wafull  = (r_load >= C_AFULL);
    assign raempty = (r_load <= C_AEMPTY);
    assign rempty  = w_rempty;
    assign rvalid  = r_rvalid;
    assign load    = r_load;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: one standard-mode and one FWFT instance, depth 3 on a 2-bit address.
module tb_fifo_sync;

    logic       clk = 1'b0;

    logic       sRst = 1'b1, sWen = 1'b0, sRen = 1'b0, sErrClr = 1'b0;
    logic [7:0] sWdata = '0;
    logic       sWfull, sWafull, sRvalid, sRempty, sRaempty, sOvf, sUdf;
    logic [7:0] sRdata;
    logic [2:0] sLoad;

    logic       fRst = 1'b1, fWen = 1'b0, fRen = 1'b0, fErrClr = 1'b0;
    logic [7:0] fWdata = '0;
    logic       fWfull, fWafull, fRvalid, fRempty, fRaempty, fOvf, fUdf;
    logic [7:0] fRdata;
    logic [2:0] fLoad;

    int checkCount = 0;
    int errorCount = 0;

    fifo_sync #(
        .ADDR_W(2), .DATA_W(8), .WORDS_TOTAL(3), .FWFT(0), .AFULL_THR(2), .AEMPTY_THR(1)
    ) dutStd (
        .clk(clk), .rst(sRst), .wdata(sWdata), .wen(sWen), .wfull(sWfull), .wafull(sWafull),
        .ren(sRen), .rdata(sRdata), .rvalid(sRvalid), .rempty(sRempty), .raempty(sRaempty),
        .load(sLoad), .ovf(sOvf), .udf(sUdf), .err_clr(sErrClr)
    );

    fifo_sync #(
        .ADDR_W(2), .DATA_W(8), .WORDS_TOTAL(3), .FWFT(1), .AFULL_THR(2), .AEMPTY_THR(1)
    ) dutFwft (
        .clk(clk), .rst(fRst), .wdata(fWdata), .wen(fWen), .wfull(fWfull), .wafull(fWafull),
        .ren(fRen), .rdata(fRdata), .rvalid(fRvalid), .rempty(fRempty), .raempty(fRaempty),
        .load(fLoad), .ovf(fOvf), .udf(fUdf), .err_clr(fErrClr)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rstV, input logic wenV, input logic renV,
                                 input logic [7:0] wd, input logic clrV);
        sRst = rstV; sWen = wenV; sRen = renV; sWdata = wd; sErrClr = clrV;
        tick();
        sRst = 1'b0; sWen = 1'b0; sRen = 1'b0; sErrClr = 1'b0;
    endtask

    task automatic applyFwftStimulus(input logic rstV, input logic wenV, input logic renV,
                                     input logic [7:0] wd, input logic clrV);
        fRst = rstV; fWen = wenV; fRen = renV; fWdata = wd; fErrClr = clrV;
        tick();
        fRst = 1'b0; fWen = 1'b0; fRen = 1'b0; fErrClr = 1'b0;
    endtask

    // Directed sequence; every expected value below is worked out by hand.
    initial begin
        logic [7:0] v;
        tick();
        tick();
        sRst = 1'b0;
        fRst = 1'b0;

        checkOutput("rst load",    32'(sLoad), 0);
        checkOutput("rst rempty",  32'(sRempty), 1);
        checkOutput("rst raempty", 32'(sRaempty), 1);
        checkOutput("rst wfull",   32'(sWfull), 0);
        checkOutput("rst wafull",  32'(sWafull), 0);
        checkOutput("rst rvalid",  32'(sRvalid), 0);
        checkOutput("rst rdata",   32'(sRdata), 0);
        checkOutput("rst ovf",     32'(sOvf), 0);
        checkOutput("rst udf",     32'(sUdf), 0);
        checkOutput("rst f rempty", 32'(fRempty), 1);

        applyStimulus(0, 1, 0, 8'h11, 0);
        checkOutput("w1 load",    32'(sLoad), 1);
        checkOutput("w1 rempty",  32'(sRempty), 0);
        checkOutput("w1 raempty", 32'(sRaempty), 1);
        checkOutput("w1 wafull",  32'(sWafull), 0);
        applyStimulus(0, 1, 0, 8'h22, 0);
        checkOutput("w2 wafull",  32'(sWafull), 1);
        checkOutput("w2 raempty", 32'(sRaempty), 0);
        applyStimulus(0, 1, 0, 8'h33, 0);
        checkOutput("w3 load",  32'(sLoad), 3);
        checkOutput("w3 wfull", 32'(sWfull), 1);
        applyStimulus(0, 1, 0, 8'h44, 0);
        checkOutput("w4 ovf",  32'(sOvf), 1);
        checkOutput("w4 load", 32'(sLoad), 3);

        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("r1 rvalid", 32'(sRvalid), 1);
        checkOutput("r1 rdata",  32'(sRdata), 32'h11);
        checkOutput("r1 wfull",  32'(sWfull), 0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("idle rvalid", 32'(sRvalid), 0);
        checkOutput("idle rdata hold", 32'(sRdata), 32'h11);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("r2 rdata", 32'(sRdata), 32'h22);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("r3 rdata",  32'(sRdata), 32'h33);
        checkOutput("r3 rempty", 32'(sRempty), 1);
        checkOutput("r3 load",   32'(sLoad), 0);
        checkOutput("r3 udf",    32'(sUdf), 0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("clr ovf", 32'(sOvf), 0);

        applyStimulus(0, 1, 0, 8'h80, 0);
        for (int i = 0; i < 10; i++) begin
            v = 8'h81 + 8'(i);
            applyStimulus(0, 1, 1, v, 0);
            checkOutput("wrap rdata",  32'(sRdata), 32'(8'h80 + 8'(i)));
            checkOutput("wrap rvalid", 32'(sRvalid), 1);
            checkOutput("wrap load",   32'(sLoad), 1);
            checkOutput("wrap flags",  32'({sOvf, sUdf, sWfull}), 0);
        end
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("wrap tail", 32'(sRdata), 32'h8A);
        checkOutput("wrap empty", 32'(sLoad), 0);

        applyStimulus(0, 1, 0, 8'hA1, 0);
        applyStimulus(0, 1, 0, 8'hA2, 0);
        applyStimulus(0, 1, 0, 8'hA3, 0);
        applyStimulus(0, 1, 1, 8'hA4, 0);
        checkOutput("full wr+rd load",  32'(sLoad), 2);
        checkOutput("full wr+rd ovf",   32'(sOvf), 1);
        checkOutput("full wr+rd rdata", 32'(sRdata), 32'hA1);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("drain a2", 32'(sRdata), 32'hA2);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("drain a3", 32'(sRdata), 32'hA3);
        applyStimulus(0, 1, 1, 8'hB1, 0);
        checkOutput("empty wr+rd load",   32'(sLoad), 1);
        checkOutput("empty wr+rd udf",    32'(sUdf), 1);
        checkOutput("empty wr+rd rvalid", 32'(sRvalid), 0);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("b1 rdata", 32'(sRdata), 32'hB1);
        applyStimulus(0, 0, 1, 8'h00, 1);
        checkOutput("set beats clr udf", 32'(sUdf), 1);
        checkOutput("clr ovf only",      32'(sOvf), 0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("clr udf", 32'(sUdf), 0);

        applyStimulus(0, 1, 0, 8'h61, 0);
        applyStimulus(0, 1, 0, 8'h62, 0);
        checkOutput("pre-rst load", 32'(sLoad), 2);
        applyStimulus(1, 1, 1, 8'h77, 0);
        checkOutput("mid rst load",   32'(sLoad), 0);
        checkOutput("mid rst rempty", 32'(sRempty), 1);
        checkOutput("mid rst rvalid", 32'(sRvalid), 0);
        checkOutput("mid rst rdata",  32'(sRdata), 0);
        applyStimulus(0, 1, 0, 8'h5A, 0);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("post rst rdata", 32'(sRdata), 32'h5A);

        applyFwftStimulus(0, 1, 0, 8'hA5, 0);
        checkOutput("fwft N+1 rvalid", 32'(fRvalid), 0);
        checkOutput("fwft N+1 load",   32'(fLoad), 1);
        applyFwftStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("fwft N+2 rvalid", 32'(fRvalid), 1);
        checkOutput("fwft N+2 rdata",  32'(fRdata), 32'hA5);
        checkOutput("fwft N+2 rempty", 32'(fRempty), 0);
        applyFwftStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("fwft pop rempty", 32'(fRempty), 1);
        checkOutput("fwft pop load",   32'(fLoad), 0);

        applyFwftStimulus(0, 1, 0, 8'h01, 0);
        applyFwftStimulus(0, 1, 0, 8'h02, 0);
        applyFwftStimulus(0, 1, 0, 8'h03, 0);
        checkOutput("fwft head", 32'(fRdata), 32'h01);
        checkOutput("fwft full", 32'(fWfull), 1);
        applyFwftStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("fwft b2b 02", 32'(fRdata), 32'h02);
        checkOutput("fwft b2b v2", 32'(fRvalid), 1);
        applyFwftStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("fwft b2b 03", 32'(fRdata), 32'h03);
        checkOutput("fwft b2b v3", 32'(fRvalid), 1);
        checkOutput("fwft b2b load", 32'(fLoad), 1);
        applyFwftStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("fwft drained", 32'(fRempty), 1);
        applyFwftStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("fwft udf", 32'(fUdf), 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have parameter WORDS_TOTAL, default 2**ADDR_W, usable capacity, legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter FWFT, default 0: 0 is standard read, 1 is first-word-fall-through.
REQ-005 SHALL have parameter AFULL_THR, default WORDS_TOTAL-1, almost-full threshold in words.
REQ-006 SHALL have parameter AEMPTY_THR, default 1, almost-empty threshold in words.
REQ-007 SHALL have ports, one per line:
- clk  in  1  sole clock; one clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wdata  in  DATA_W  write data.
- wen  in  1  write request.
- wfull  out  1  load == WORDS_TOTAL.
- wafull  out  1  load >= AFULL_THR.
- ren  in  1  read request (FWFT: pop/acknowledge).
- rdata  out  DATA_W  read data.
- rvalid  out  1  rdata valid.
- rempty  out  1  no word readable.
- raempty  out  1  load <= AEMPTY_THR.
- load  out  ADDR_W+1  words accepted and not yet popped.
- ovf  out  1  sticky overflow.
- udf  out  1  sticky underflow.
- err_clr  in  1  clears ovf and udf.

Function
REQ-008 SHALL accept a write when wen & ~wfull, storing wdata at the write pointer.
REQ-009 SHALL wrap write and read pointers from WORDS_TOTAL-1 to 0, including non-power-of-two WORDS_TOTAL.
REQ-010 SHALL keep load as a register: +1 on accepted write only, -1 on accepted pop only, unchanged on both or neither.
REQ-011 SHALL derive wfull, wafull, raempty from the load register, so flags update the cycle after the causing event.
REQ-012 Standard mode SHALL accept a read when ren & ~rempty; rdata valid with rvalid=1 exactly one cycle later; rvalid=0 otherwise; rdata held between reads.
REQ-013 Standard mode SHALL set rempty = (load == 0); a word written in cycle N is readable (rempty=0) from cycle N+1.
REQ-014 FWFT mode SHALL present the head word on rdata with rvalid=1 without ren; ren & rvalid pops it; rempty = ~rvalid.
REQ-015 FWFT mode SHALL show a word written into an empty FIFO in cycle N on rdata/rvalid at cycle N+2; back-to-back pops SHALL sustain one word per cycle.
REQ-016 When full, SHALL reject a simultaneous write and pop's write (wfull gates wen); only the pop is accepted.
REQ-017 When empty, SHALL reject a simultaneous write and read's read; only the write is accepted.
REQ-018 SHALL set ovf on wen & wfull and udf on ren & rempty; both hold until err_clr or rst; set has priority over err_clr in the same cycle.
REQ-019 Rejected writes and reads SHALL not change memory, pointers, load or rdata.

Reset
REQ-020 On rst=1 at a clock edge, SHALL set pointers=0, load=0, rvalid=0, rempty=1, raempty=1, wfull=0, wafull=0 (AFULL_THR>0), ovf=0, udf=0, rdata=0.
REQ-021 rst mid-operation SHALL discard all stored words; memory contents need not clear.
REQ-022 SHALL ignore wen and ren in the reset cycle.

Structure
REQ-023 SHALL place a fifo_mode_t enum (FIFO_STD, FIFO_FWFT) and a load-width helper function in shared package fifo_pkg.
REQ-024 SHALL instantiate the existing dpram with both ports on clk; no other sub-module.

Verification
Use ADDR_W=2, WORDS_TOTAL=3, DATA_W=8 unless stated.
REQ-025 Standard fill/drain: write 0x11,0x22,0x33 -> wfull=1, load=3; 4th write 0x44 -> ovf=1; three reads -> 0x11,0x22,0x33 each one cycle after ren; rempty=1.
REQ-026 Wrap: 10 cycles of simultaneous write/read at load=1 with an incrementing pattern -> in-order data, load stays 1, no flags.
REQ-027 FWFT latency: write 0xA5 at cycle N into empty -> rvalid=1, rdata=0xA5 at N+2; ren -> rempty=1 next cycle, load=0.
REQ-028 Boundaries: at full, wen+ren -> load=2, ovf=1; at empty, wen+ren -> load=1, udf=1; err_clr -> ovf=udf=0.
REQ-029 Reset mid-stream: rst with load=2 -> next cycle load=0, rempty=1, rvalid=0; a following write 0x5A reads back 0x5A.
REQ-030 Thresholds: AFULL_THR=2, AEMPTY_THR=1 -> wafull rises on the 2nd write; raempty falls on the 2nd write.
